// File: rtl/neuron_wr_sequencer_if.sv
// Neuron register-write bus: config-memory read port plus the neuron write strobes and data.
// The master modport is the sequencer side; the slave modport is the memory/neuron side.
interface neuron_wr_sequencer_if #(
  parameter int MU_DATA_WIDTH    = 16,
  parameter int VMEM_DATA_WIDTH  = 16,
  parameter int Q_DATA_WIDTH     = 2,
  parameter int SPIKE_ADDR_WIDTH = 10,
  parameter int CFG_ADDR_WIDTH   = 12,
  parameter int CFG_DATA_WIDTH   = 16
);
  logic                        cfg_rd_en;
  logic [CFG_ADDR_WIDTH-1:0]   cfg_addr;
  logic [CFG_DATA_WIDTH-1:0]   cfg_rdata;
  logic                        en_neuron;
  logic                        wrVmem;
  logic                        wrNeuronI;
  logic                        wrMu;
  logic                        wrQ;
  logic [VMEM_DATA_WIDTH-1:0]  Vmem_out;
  logic [SPIKE_ADDR_WIDTH-1:0] neuronI_out;
  logic [MU_DATA_WIDTH-1:0]    mu_out;
  logic [Q_DATA_WIDTH-1:0]     Q_out;
  logic                        neuronWrDone;

  modport master (
    output cfg_rd_en, cfg_addr, en_neuron, wrVmem, wrNeuronI, wrMu, wrQ,
           Vmem_out, neuronI_out, mu_out, Q_out,
    input  cfg_rdata, neuronWrDone
  );

  modport slave (
    input  cfg_rd_en, cfg_addr, en_neuron, wrVmem, wrNeuronI, wrMu, wrQ,
           Vmem_out, neuronI_out, mu_out, Q_out,
    output cfg_rdata, neuronWrDone
  );
endinterface

// File: rtl/neuron_wr_sequencer.sv
// Fetches one neuron's config words from sync-read memory and replays them as neuron write strobes.
// Optional WAIT_DONE timeout is enabled by defining NEURON_WR_TIMEOUT_EN.
module neuron_wr_sequencer #(
  parameter int MU_DATA_WIDTH    = 16,
  parameter int VMEM_DATA_WIDTH  = 16,
  parameter int Q_ADDR_WIDTH     = 10,
  parameter int Q_DATA_WIDTH     = 2,
  parameter int SPIKE_ADDR_WIDTH = 10,
  parameter int CFG_ADDR_WIDTH   = 12,
  parameter int CFG_DATA_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic                      start,
  input  logic [CFG_ADDR_WIDTH-1:0] base_addr,
  input  logic [Q_ADDR_WIDTH:0]     num_q,
  output logic                      busy,
  output logic                      done,
  output logic                      wr_err,
  neuron_wr_sequencer_if.master     bus
);

  localparam int QPW  = CFG_DATA_WIDTH / Q_DATA_WIDTH;
  localparam int QC_W = $clog2(QPW + 1);

  if (QPW < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("neuron_wr_sequencer: bad Q_DATA_WIDTH or TIMEOUT_CYCLES");
  end

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RD_VMEM   = 4'd1;
  localparam logic [3:0] S_WR_VMEM   = 4'd2;
  localparam logic [3:0] S_RD_NI     = 4'd3;
  localparam logic [3:0] S_WR_NI     = 4'd4;
  localparam logic [3:0] S_RD_MU     = 4'd5;
  localparam logic [3:0] S_WR_MU     = 4'd6;
  localparam logic [3:0] S_RD_Q      = 4'd7;
  localparam logic [3:0] S_WR_Q      = 4'd8;
  localparam logic [3:0] S_WAIT_DONE = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  logic [3:0]                state;
  logic [Q_ADDR_WIDTH:0]     q_left;
  logic [QC_W-1:0]           q_cnt;
  logic                      q_first;
  logic [CFG_DATA_WIDTH-1:0] q_shift;
  logic                      tail;
  logic [CFG_DATA_WIDTH-1:0] q_word;
  logic [QC_W-1:0]           q_cnt_next;

  // The first entry of a Q word comes straight off cfg_rdata; later entries from the shifter.
  assign q_word     = q_first ? bus.cfg_rdata : q_shift;
  assign q_cnt_next = q_first ? QC_W'(1) : q_cnt + 1'b1;

`ifdef NEURON_WR_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [TO_W-1:0] wait_cnt;
  logic            timeout_hit;

  always_ff @(posedge clk) begin
    if (!reset_l || state != S_WAIT_DONE) wait_cnt <= '0;
    else                                  wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign wr_err = 1'b0;
`endif

  // tail marks the cycle in which the final strobe is visible, so WAIT_DONE starts one cycle later.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      bus.en_neuron   <= 1'b0;
      bus.cfg_rd_en   <= 1'b0;
      bus.cfg_addr    <= '0;
      bus.wrVmem      <= 1'b0;
      bus.wrNeuronI   <= 1'b0;
      bus.wrMu        <= 1'b0;
      bus.wrQ         <= 1'b0;
      bus.Vmem_out    <= '0;
      bus.neuronI_out <= '0;
      bus.mu_out      <= '0;
      bus.Q_out       <= '0;
      q_left          <= '0;
      q_cnt           <= '0;
      q_first         <= 1'b0;
      q_shift         <= '0;
      tail            <= 1'b0;
`ifdef NEURON_WR_TIMEOUT_EN
      wr_err          <= 1'b0;
`endif
    end else begin
      bus.cfg_rd_en <= 1'b0;
      bus.wrVmem    <= 1'b0;
      bus.wrNeuronI <= 1'b0;
      bus.wrMu      <= 1'b0;
      bus.wrQ       <= 1'b0;
      done          <= 1'b0;
`ifdef NEURON_WR_TIMEOUT_EN
      wr_err        <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            busy          <= 1'b1;
            bus.en_neuron <= 1'b1;
            bus.cfg_rd_en <= 1'b1;
            bus.cfg_addr  <= base_addr;
            q_left        <= num_q;
            state         <= S_RD_VMEM;
          end
        end
        S_RD_VMEM: state <= S_WR_VMEM;
        S_WR_VMEM: begin
          bus.Vmem_out  <= bus.cfg_rdata[VMEM_DATA_WIDTH-1:0];
          bus.wrVmem    <= 1'b1;
          bus.cfg_rd_en <= 1'b1;
          bus.cfg_addr  <= bus.cfg_addr + 1'b1;
          state         <= S_RD_NI;
        end
        S_RD_NI: state <= S_WR_NI;
        S_WR_NI: begin
          bus.neuronI_out <= bus.cfg_rdata[SPIKE_ADDR_WIDTH-1:0];
          bus.wrNeuronI   <= 1'b1;
          bus.cfg_rd_en   <= 1'b1;
          bus.cfg_addr    <= bus.cfg_addr + 1'b1;
          state           <= S_RD_MU;
        end
        S_RD_MU: state <= S_WR_MU;
        S_WR_MU: begin
          if (tail) begin
            tail  <= 1'b0;
            state <= S_WAIT_DONE;
          end else begin
            bus.mu_out <= bus.cfg_rdata[MU_DATA_WIDTH-1:0];
            bus.wrMu   <= 1'b1;
            if (q_left == '0) begin
              tail <= 1'b1;
            end else begin
              bus.cfg_rd_en <= 1'b1;
              bus.cfg_addr  <= bus.cfg_addr + 1'b1;
              state         <= S_RD_Q;
            end
          end
        end
        S_RD_Q: begin
          q_first <= 1'b1;
          state   <= S_WR_Q;
        end
        S_WR_Q: begin
          if (tail) begin
            tail  <= 1'b0;
            state <= S_WAIT_DONE;
          end else begin
            bus.Q_out <= q_word[Q_DATA_WIDTH-1:0];
            bus.wrQ   <= 1'b1;
            q_shift   <= q_word >> Q_DATA_WIDTH;
            q_left    <= q_left - 1'b1;
            q_cnt     <= q_cnt_next;
            q_first   <= 1'b0;
            // Prefetch the next word so its read overlaps the last strobe of this one.
            if (q_left == {{Q_ADDR_WIDTH{1'b0}}, 1'b1}) begin
              tail <= 1'b1;
            end else if (q_cnt_next == QC_W'(QPW)) begin
              bus.cfg_rd_en <= 1'b1;
              bus.cfg_addr  <= bus.cfg_addr + 1'b1;
              state         <= S_RD_Q;
            end
          end
        end
        S_WAIT_DONE: begin
          if (bus.neuronWrDone) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
`ifdef NEURON_WR_TIMEOUT_EN
          else if (timeout_hit) begin
            done   <= 1'b1;
            wr_err <= 1'b1;
            state  <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          busy          <= 1'b0;
          bus.en_neuron <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_wr_sequencer.sv
// Scoreboard bench for neuron_wr_sequencer: a reference model queues expected reads/strobes/done,
// a negedge monitor pops and compares them; each scenario task also checks outputs inline.
module tb_neuron_wr_sequencer;

  localparam int BIG = 32'h3fff_ffff;
  localparam int K_VMEM = 0, K_NI = 1, K_MU = 2, K_Q = 3, K_DONE = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        start;
  logic [11:0] base_addr;
  logic [10:0] num_q;
  logic        busy, done, wr_err;
  logic [15:0] mem [0:4095];

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;
  int  busy_from = 1;
  int  busy_to = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neuron_wr_sequencer_if #(
    .MU_DATA_WIDTH(16), .VMEM_DATA_WIDTH(16), .Q_DATA_WIDTH(2),
    .SPIKE_ADDR_WIDTH(10), .CFG_ADDR_WIDTH(12), .CFG_DATA_WIDTH(16)
  ) bus ();

  neuron_wr_sequencer #(
    .MU_DATA_WIDTH(16), .VMEM_DATA_WIDTH(16), .Q_ADDR_WIDTH(10), .Q_DATA_WIDTH(2),
    .SPIKE_ADDR_WIDTH(10), .CFG_ADDR_WIDTH(12), .CFG_DATA_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .base_addr(base_addr), .num_q(num_q),
    .busy(busy), .done(done), .wr_err(wr_err), .bus(bus)
  );

  // Sync-read config memory model
  always @(posedge clk) if (bus.cfg_rd_en === 1'b1) bus.cfg_rdata <= mem[bus.cfg_addr];

  always @(negedge clk) begin : monitor
    ev_t         e;
    int          nstb;
    int          kind;
    logic [15:0] data;
    logic        exp_busy;
    if (mon_en) begin
      if (bus.cfg_rd_en === 1'b1) begin
        n_checks++;
        if (rd_q.size() == 0)
          $display("[TB] FAIL rd_unexpected cyc=%0d got addr %h, expected no read", cyc, bus.cfg_addr);
        else begin
          e = rd_q.pop_front();
          if (e.cyc != cyc || e.data[11:0] !== bus.cfg_addr)
            $display("[TB] FAIL rd_addr cyc=%0d got addr %h, expected addr %h at cyc %0d",
                     cyc, bus.cfg_addr, e.data[11:0], e.cyc);
          else n_pass++;
        end
      end
      nstb = int'(bus.wrVmem === 1'b1) + int'(bus.wrNeuronI === 1'b1) +
             int'(bus.wrMu === 1'b1) + int'(bus.wrQ === 1'b1);
      n_checks++;
      if (nstb > 1) $display("[TB] FAIL strobe_overlap cyc=%0d got %0d strobes, expected <=1", cyc, nstb);
      else n_pass++;
      for (int s = 0; s < 2; s++) begin
        kind = -1;
        data = 16'h0;
        if (s == 0) begin
          if (bus.wrVmem === 1'b1)         begin kind = K_VMEM; data = bus.Vmem_out; end
          else if (bus.wrNeuronI === 1'b1) begin kind = K_NI;   data = {6'b0, bus.neuronI_out}; end
          else if (bus.wrMu === 1'b1)      begin kind = K_MU;   data = bus.mu_out; end
          else if (bus.wrQ === 1'b1)       begin kind = K_Q;    data = {14'b0, bus.Q_out}; end
        end else if (done === 1'b1) begin
          kind = K_DONE; data = {15'b0, wr_err};
        end
        if (kind >= 0) begin
          n_checks++;
          if (wr_q.size() == 0)
            $display("[TB] FAIL wr_unexpected cyc=%0d got kind %0d data %h, expected none", cyc, kind, data);
          else begin
            e = wr_q.pop_front();
            if (e.cyc != cyc || e.kind != kind || e.data !== data)
              $display("[TB] FAIL wr_event cyc=%0d got kind %0d data %h, expected kind %0d data %h at cyc %0d",
                       cyc, kind, data, e.kind, e.data, e.cyc);
            else n_pass++;
          end
        end
      end
      n_checks++;
      if (done !== 1'b1 && wr_err !== 1'b0)
        $display("[TB] FAIL wr_err_idle cyc=%0d got %b, expected 0", cyc, wr_err);
      else n_pass++;
      exp_busy = (cyc >= busy_from && cyc <= busy_to);
      n_checks++;
      if (busy !== exp_busy || bus.en_neuron !== exp_busy)
        $display("[TB] FAIL busy cyc=%0d got busy %b en %b, expected %b", cyc, busy, bus.en_neuron, exp_busy);
      else n_pass++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: queue every read and strobe of one run started in cycle t0, up to cutoff
  task automatic model_run(input logic [11:0] base, input int nq, input int t0, input int cutoff,
                           output int entry);
    int          c;
    int          rem;
    int          n;
    logic [11:0] a;
    logic [15:0] w;
    c = t0 + 1;
    a = base;
    for (int k = 0; k < 3; k++) begin
      w = mem[a];
      if (k == 1) w = {6'b0, w[9:0]};
      if (c <= cutoff)     rd_q.push_back('{c, 0, {4'b0, a}});
      if (c + 2 <= cutoff) wr_q.push_back('{c + 2, k, w});
      a = a + 12'd1;
      c = c + 2;
    end
    rem = nq;
    while (rem > 0) begin
      if (c <= cutoff) rd_q.push_back('{c, 0, {4'b0, a}});
      n = (rem < 8) ? rem : 8;
      w = mem[a];
      for (int j = 0; j < n; j++)
        if (c + 2 + j <= cutoff) wr_q.push_back('{c + 2 + j, K_Q, {14'b0, w[2*j +: 2]}});
      c = c + 1 + n;
      rem = rem - n;
      a = a + 12'd1;
    end
    entry = c + 1;
  endtask

  task automatic test_reset();
    reset_l = 1'b0; start = 1'b0; base_addr = '0; num_q = '0; bus.neuronWrDone = 1'b0;
    step(3);
    n_checks++;
    if ({busy, done, wr_err, bus.en_neuron} !== 4'b0)
      $display("[TB] FAIL reset_ctrl got %b, expected 0000", {busy, done, wr_err, bus.en_neuron});
    else n_pass++;
    n_checks++;
    if ({bus.cfg_rd_en, bus.cfg_addr} !== 13'b0)
      $display("[TB] FAIL reset_cfg got %h, expected 0", {bus.cfg_rd_en, bus.cfg_addr});
    else n_pass++;
    n_checks++;
    if ({bus.wrVmem, bus.wrNeuronI, bus.wrMu, bus.wrQ} !== 4'b0)
      $display("[TB] FAIL reset_strobes got %b, expected 0000", {bus.wrVmem, bus.wrNeuronI, bus.wrMu, bus.wrQ});
    else n_pass++;
    n_checks++;
    if ({bus.Vmem_out, bus.neuronI_out, bus.mu_out, bus.Q_out} !== 44'b0)
      $display("[TB] FAIL reset_data got %h, expected 0", {bus.Vmem_out, bus.neuronI_out, bus.mu_out, bus.Q_out});
    else n_pass++;
    reset_l = 1'b1;
    step(1);
    mon_en = 1'b1;
  endtask

  task automatic test_nominal();
    int t0, entry, rel;
    t0 = cyc;
    model_run(12'h010, 10, t0, BIG, entry);
    rel = entry - t0 + 2;
    wr_q.push_back('{entry + 3, K_DONE, 16'h0});
    busy_from = t0 + 1; busy_to = entry + 3;
    for (int k = 0; k < rel + 6; k++) begin
      start = (k == 0); base_addr = 12'h010; num_q = 11'd10;
      bus.neuronWrDone = (k == rel);
      step(1);
    end
    n_checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0)
      $display("[TB] FAIL nominal_drain got %0d/%0d left, expected 0/0", rd_q.size(), wr_q.size());
    else n_pass++;
    n_checks++;
    if (bus.mu_out !== 16'h5678 || bus.Q_out !== 2'd2)
      $display("[TB] FAIL nominal_hold got mu %h q %0d, expected mu 5678 q 2", bus.mu_out, bus.Q_out);
    else n_pass++;
  endtask

  task automatic test_zero_q();
    int t0, entry, rel;
    t0 = cyc;
    model_run(12'h010, 0, t0, BIG, entry);
    rel = entry - t0;
    wr_q.push_back('{entry + 1, K_DONE, 16'h0});
    busy_from = t0 + 1; busy_to = entry + 1;
    for (int k = 0; k < rel + 5; k++) begin
      start = (k == 0); base_addr = 12'h010; num_q = 11'd0;
      bus.neuronWrDone = (k == rel);
      step(1);
    end
    n_checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0)
      $display("[TB] FAIL zero_q_drain got %0d/%0d left, expected 0/0", rd_q.size(), wr_q.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    int t0, entry, rel;
    mem[12'hFFE] = 16'hABCD; mem[12'hFFF] = 16'h0155;
    mem[12'h000] = 16'h0F0F; mem[12'h001] = 16'h02D8;
    t0 = cyc;
    model_run(12'hFFE, 5, t0, BIG, entry);
    rel = entry - t0 + 1;
    wr_q.push_back('{entry + 2, K_DONE, 16'h0});
    busy_from = t0 + 1; busy_to = entry + 2;
    for (int k = 0; k < rel + 5; k++) begin
      start = (k == 0); base_addr = 12'hFFE; num_q = 11'd5;
      bus.neuronWrDone = (k == rel);
      step(1);
    end
    n_checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0)
      $display("[TB] FAIL wrap_drain got %0d/%0d left, expected 0/0", rd_q.size(), wr_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t0, entry, entry2, rel, rel2;
    t0 = cyc;
    model_run(12'h010, 10, t0, BIG, entry);
    rel = entry - t0 + 2;
    wr_q.push_back('{entry + 3, K_DONE, 16'h0});
    busy_from = t0 + 1; busy_to = entry + 3;
    rel2 = BIG;
    for (int k = 0; k < 60; k++) begin
      start = 1'b0; base_addr = 12'h100; num_q = 11'd3;
      if (k == 0) begin start = 1'b1; base_addr = 12'h010; num_q = 11'd10; end
      if (k == 4 || k == rel + 1) start = 1'b1;
      if (k == rel + 2) begin
        start = 1'b1; base_addr = 12'h010; num_q = 11'd2;
        model_run(12'h010, 2, cyc, BIG, entry2);
        rel2 = entry2 - t0;
        wr_q.push_back('{entry2 + 1, K_DONE, 16'h0});
        busy_from = cyc + 1; busy_to = entry2 + 1;
      end
      bus.neuronWrDone = (k == 5 || k == rel || k == rel2);
      step(1);
      if (k > rel2 + 4) break;
    end
    n_checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0)
      $display("[TB] FAIL b2b_drain got %0d/%0d left, expected 0/0", rd_q.size(), wr_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t0, entry;
    t0 = cyc;
    model_run(12'h010, 10, t0, t0 + 6, entry);
    busy_from = t0 + 1; busy_to = t0 + 6;
    for (int k = 0; k < 20; k++) begin
      start = (k == 0); base_addr = 12'h010; num_q = 11'd10;
      reset_l = !(k >= 6 && k <= 8);
      bus.neuronWrDone = (k == 12);
      step(1);
      if (k == 6) begin
        n_checks++;
        if ({busy, done, bus.cfg_rd_en, bus.wrVmem, bus.wrNeuronI, bus.wrMu, bus.wrQ} !== 7'b0)
          $display("[TB] FAIL reset_mid_ctrl got %b, expected 0",
                   {busy, done, bus.cfg_rd_en, bus.wrVmem, bus.wrNeuronI, bus.wrMu, bus.wrQ});
        else n_pass++;
        n_checks++;
        if ({bus.cfg_addr, bus.Vmem_out, bus.neuronI_out, bus.mu_out} !== 54'b0)
          $display("[TB] FAIL reset_mid_data got %h, expected 0",
                   {bus.cfg_addr, bus.Vmem_out, bus.neuronI_out, bus.mu_out});
        else n_pass++;
      end
    end
    n_checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0)
      $display("[TB] FAIL reset_mid_drain got %0d/%0d left, expected 0/0", rd_q.size(), wr_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int t0, entry, rel;
    t0 = cyc;
    model_run(12'h010, 1, t0, BIG, entry);
    rel = entry - t0;
    busy_from = t0 + 1;
`ifdef NEURON_WR_TIMEOUT_EN
    wr_q.push_back('{entry + 16, K_DONE, 16'h1});
    busy_to = entry + 16;
    for (int k = 0; k < rel + 20; k++) begin
      start = (k == 0); base_addr = 12'h010; num_q = 11'd1; bus.neuronWrDone = 1'b0;
      step(1);
    end
`else
    busy_to = BIG;
    for (int k = 0; k < rel + 40; k++) begin
      start = (k == 0); base_addr = 12'h010; num_q = 11'd1; bus.neuronWrDone = 1'b0;
      step(1);
    end
    n_checks++;
    if (busy !== 1'b1 || wr_err !== 1'b0)
      $display("[TB] FAIL no_timeout got busy %b wr_err %b, expected 1 0", busy, wr_err);
    else n_pass++;
    busy_to = cyc;
    reset_l = 1'b0;
    step(1);
    reset_l = 1'b1;
    step(2);
`endif
    n_checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0)
      $display("[TB] FAIL timeout_drain got %0d/%0d left, expected 0/0", rd_q.size(), wr_q.size());
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 40503 + 17);
    mem[12'h010] = 16'h1234; mem[12'h011] = 16'h003A; mem[12'h012] = 16'h5678;
    mem[12'h013] = 16'hE4E4; mem[12'h014] = 16'h000B;
    bus.cfg_rdata = '0;
    test_reset();
    test_nominal();
    test_zero_q();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_zero_q();
    test_timeout();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
